// File: rtl/img_window_gen.sv
// Sliding 5x5 window generator: streams a row-major image through K-1 line buffers and a
// KxK shift window, emitting one {X, Y, IMGIN} per handshake. Optional macro: IMGWIN_BIN_EN.
module img_window_gen #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 5,
  parameter int PW     = 8,
  parameter int THRESH = 128
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              START,
  input  logic [PW-1:0]     PIXIN,
  input  logic              PIX_VALID,
  output logic              PIX_READY,
  input  logic              WIN_READY,
  output logic              WIN_VALID,
  output logic [4:0]        X,
  output logic [4:0]        Y,
  output logic [K*K*PW-1:0] IMGIN,
  output logic              BUSY,
  output logic              FRAME_DONE
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

`ifdef IMGWIN_BIN_EN
  localparam bit BIN_EN = 1'b1;
`else
  localparam bit BIN_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             col_q, col_d;
  logic [RW-1:0]             row_q, row_d;
  logic                      win_valid_q, win_valid_d;
  logic [4:0]                x_q, x_d;
  logic [4:0]                y_q, y_d;
  logic                      frame_done_q, frame_done_d;
  logic [K*K-1:0][PW-1:0]    win_q;
  logic [K-1:0][PW-1:0]      col_v;
  logic [PW-1:0]             pix_bin;
  logic [PW-1:0]             pix_store;
  logic                      pix_accept;
  logic                      win_cond;

  assign pix_bin    = (PIXIN >= PW'(THRESH)) ? {PW{1'b1}} : {PW{1'b0}};
  assign pix_store  = BIN_EN ? pix_bin : PIXIN;
  assign PIX_READY  = (state_q == S_LOAD) && (!win_valid_q || WIN_READY);
  assign pix_accept = PIX_VALID && PIX_READY;
  assign win_cond   = (row_q >= RW'(K-1)) && (col_q >= CW'(K-1));

  // Column vector for the current column: oldest row at index 0, incoming pixel at K-1.
  assign col_v[K-1] = pix_store;

  genvar gi;
  generate
    for (gi = 0; gi < K-1; gi++) begin : g_lb
      logic [PW-1:0] mem_q [IMG_W];
      assign col_v[gi] = mem_q[col_q];
      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          for (int a = 0; a < IMG_W; a++) mem_q[a] <= '0;
        end else if (pix_accept) begin
          mem_q[col_q] <= col_v[gi+1];
        end
      end
    end
  endgenerate

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      win_q <= '0;
    end else if (pix_accept) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K-1; j++) win_q[i*K+j] <= win_q[i*K+j+1];
        win_q[i*K+K-1] <= col_v[i];
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      x_q          <= x_d;
      y_q          <= y_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    win_valid_d  = win_valid_q;
    x_d          = x_q;
    y_d          = y_q;
    frame_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_LOAD;
          col_d   = '0;
          row_d   = '0;
        end
      end
      S_LOAD: begin
        if (pix_accept) begin
          if (col_q == CW'(IMG_W-1)) begin
            col_d = '0;
            if (row_q != RW'(IMG_H-1)) row_d = row_q + RW'(1);
            else                       state_d = S_DRAIN;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (win_valid_q && WIN_READY &&
            x_q == 5'(IMG_H-K) && y_q == 5'(IMG_W-K)) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // An accept implies any pending window is handshaking this cycle, so it is safe to overwrite.
    if (pix_accept) begin
      win_valid_d = win_cond;
      if (win_cond) begin
        x_d = 5'(row_q - RW'(K-1));
        y_d = 5'(col_q - CW'(K-1));
      end
    end else if (WIN_READY) begin
      win_valid_d = 1'b0;
    end
  end

  assign WIN_VALID  = win_valid_q;
  assign X          = x_q;
  assign Y          = y_q;
  assign IMGIN      = win_q;
  assign BUSY       = (state_q != S_IDLE);
  assign FRAME_DONE = frame_done_q;

endmodule
